iterative_divider: RTL and testbench
====================================

ITERATIVE_DIVIDER -- requirements
Module: iterative_divider

Interface
REQ-001 SHALL have ports: clk_i  input  1  clock, rising-edge; all state updates on this edge.
REQ-002 SHALL have ports: rst_i  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: opcode_valid_i  input  1  instruction issued to execute this cycle.
REQ-004 SHALL have ports: opcode_opcode_i  input  32  raw RV32 instruction word.
REQ-005 SHALL have ports: opcode_ra_operand_i  input  32  rs1 value (dividend).
REQ-006 SHALL have ports: opcode_rb_operand_i  input  32  rs2 value (divisor).
REQ-007 SHALL have ports: flush_i  input  1  pipeline squash; aborts any in-flight divide.
REQ-008 SHALL have ports: busy_o  output  1  divide in progress.
REQ-009 SHALL have ports: writeback_valid_o  output  1  one-cycle completion pulse (drives pipeline div_complete).
REQ-010 SHALL have ports: writeback_value_o  output  32  quotient or remainder (drives pipeline div_result).

Function
REQ-011 SHALL decode as divide only: opcode[6:0]=0110011, funct7[31:25]=0000001, funct3[14:12] in {100 DIV, 101 DIVU, 110 REM, 111 REMU}.
REQ-012 SHALL accept a request at a rising edge when opcode_valid_i=1, decode matches, busy_o=0, flush_i=0; otherwise the request is ignored with no state change.
REQ-013 SHALL ignore non-divide opcodes (incl. MUL/MULH*) entirely: busy_o stays 0, no writeback pulse.
REQ-014 SHALL on accept latch operand magnitudes: DIV/REM two's-complement absolute value of negative operands; DIVU/REMU raw values; 0x80000000 magnitude = 2^31 unsigned.
REQ-015 SHALL on accept latch sign-invert flags: quotient negate = signed op and (ra[31] XOR rb[31]) and rb!=0; remainder negate = signed op and ra[31].
REQ-016 SHALL compute by restoring shift-subtract, one quotient bit per clock, MSB first, exactly 32 iteration cycles; 64-bit partial remainder or equivalent, no early termination.
REQ-017 SHALL use a two-state FSM: IDLE (busy_o=0) -> BUSY on accept; BUSY -> IDLE after 32nd iteration; BUSY -> IDLE on flush_i.
REQ-018 SHALL assert busy_o from the edge after accept until the edge at which writeback_valid_o rises.
REQ-019 SHALL pulse writeback_valid_o high for exactly one cycle, starting 33 rising edges after the accepting edge (accept edge N -> pulse in cycle after edge N+33).
REQ-020 SHALL present on writeback_value_o the final result, after sign correction, from the pulse cycle until the next accepted request completes; value held while idle.
REQ-021 SHALL produce divide-by-zero results per RISC-V: DIV/DIVU quotient 0xFFFFFFFF; REM/REMU remainder = dividend unmodified.
REQ-022 SHALL produce signed overflow (0x80000000 / 0xFFFFFFFF) results: DIV 0x80000000, REM 0x00000000.
REQ-023 SHALL select REM/REMU remainder vs DIV/DIVU quotient by latched funct3[1], not live input.
REQ-024 SHALL on flush_i=1 in BUSY return to IDLE next edge, suppress the pending writeback_valid_o pulse, leave writeback_value_o unchanged.
REQ-025 SHALL give flush_i priority over a simultaneous opcode_valid_i: request not accepted.
REQ-026 SHALL accept a new divide in the same cycle writeback_valid_o is high (busy_o=0 then); back-to-back issue gives pulses 34 cycles apart.
REQ-027 SHALL ignore opcode_valid_i while busy_o=1 (upstream guarantees stall); latched operands unchanged.
REQ-028 SHALL keep operands/divisor stable internally; input changes after accept have no effect on the result.

Reset
REQ-029 SHALL on rst_i=1 immediately force IDLE, busy_o=0, writeback_valid_o=0, writeback_value_o=0x00000000, all iteration state zero.
REQ-030 SHALL on reset asserted mid-divide discard the operation; no pulse after reset release.
REQ-031 SHALL accept a request at the first rising edge after rst_i deasserts.

Verification
REQ-032 DIVU 100/7 accepted edge N -> busy_o 1 from N+1; writeback_valid_o single pulse after edge N+33, value 0x0000000E; REMU same operands -> 0x00000002.
REQ-033 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIV 7/-2 -> 0xFFFFFFFD; REM 7/-2 -> 0x00000001.
REQ-034 DIV 5/0 -> 0xFFFFFFFF; REMU 0xDEADBEEF/0 -> 0xDEADBEEF; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0x00000000.
REQ-035 DIVU 100/7 accepted, flush_i pulsed 10 cycles later -> busy_o 0 next cycle, no writeback pulse within 40 cycles, value unchanged; new DIVU 9/3 then returns 0x00000003 on schedule.
REQ-036 Second DIVU issued in the pulse cycle of first -> accepted; second pulse 34 cycles after first; opcode_valid_i with MUL opcode or while busy -> no effect.
REQ-037 rst_i asserted at iteration 15 -> all outputs 0 immediately; no pulse after release; next request completes correctly.

Source files
------------

// File: rtl/iterative_divider.sv
// RV32M divide/remainder unit: restoring shift-subtract, one quotient bit per
// clock, 32 iterations plus one sign-correction cycle, single-cycle completion pulse.
module iterative_divider (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        opcode_valid_i,
  input  logic [31:0] opcode_opcode_i,
  input  logic [31:0] opcode_ra_operand_i,
  input  logic [31:0] opcode_rb_operand_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        writeback_valid_o,
  output logic [31:0] writeback_value_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic [31:0] divisor_q, divisor_d;
  logic [31:0] quotient_q, quotient_d;
  logic [31:0] remainder_q, remainder_d;
  logic        neg_quot_q, neg_quot_d;
  logic        neg_rem_q, neg_rem_d;
  logic        rem_sel_q, rem_sel_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_value_q, wb_value_d;

  logic        is_div_s;
  logic        is_signed_s;
  logic        accept_s;
  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;
  logic [32:0] shifted_s;
  logic [32:0] diff_s;
  logic        ge_s;
  logic [31:0] quot_fix_s;
  logic [31:0] rem_fix_s;

  assign is_div_s    = (opcode_opcode_i[6:0] == 7'b0110011) &&
                       (opcode_opcode_i[31:25] == 7'b0000001) &&
                       opcode_opcode_i[14];
  assign is_signed_s = ~opcode_opcode_i[12];
  assign accept_s    = opcode_valid_i && is_div_s && !flush_i && (state_q == ST_IDLE);

  // Magnitude of 0x80000000 is 2^31 as an unsigned value, which negation yields naturally.
  assign mag_a_s = (is_signed_s && opcode_ra_operand_i[31]) ? (32'd0 - opcode_ra_operand_i)
                                                            : opcode_ra_operand_i;
  assign mag_b_s = (is_signed_s && opcode_rb_operand_i[31]) ? (32'd0 - opcode_rb_operand_i)
                                                            : opcode_rb_operand_i;

  // The dividend is shifted out of quotient_q MSB first while quotient bits fill from the LSB.
  assign shifted_s  = {remainder_q, quotient_q[31]};
  assign ge_s       = (shifted_s >= {1'b0, divisor_q});
  assign diff_s     = shifted_s - {1'b0, divisor_q};
  assign quot_fix_s = neg_quot_q ? (32'd0 - quotient_q) : quotient_q;
  assign rem_fix_s  = neg_rem_q ? (32'd0 - remainder_q) : remainder_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    divisor_d   = divisor_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    neg_quot_d  = neg_quot_q;
    neg_rem_d   = neg_rem_q;
    rem_sel_d   = rem_sel_q;
    wb_valid_d  = 1'b0;
    wb_value_d  = wb_value_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d     = ST_BUSY;
          count_d     = 6'd0;
          divisor_d   = mag_b_s;
          quotient_d  = mag_a_s;
          remainder_d = 32'd0;
          neg_quot_d  = is_signed_s && (opcode_ra_operand_i[31] ^ opcode_rb_operand_i[31]) &&
                        (opcode_rb_operand_i != 32'd0);
          neg_rem_d   = is_signed_s && opcode_ra_operand_i[31];
          rem_sel_d   = opcode_opcode_i[13];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (flush_i) begin
          state_d = ST_IDLE;
          count_d = 6'd0;
        end else if (count_q == 6'd32) begin
          state_d    = ST_IDLE;
          count_d    = 6'd0;
          wb_valid_d = 1'b1;
          wb_value_d = rem_sel_q ? rem_fix_s : quot_fix_s;
        end else begin
          count_d     = count_q + 6'd1;
          quotient_d  = {quotient_q[30:0], ge_s};
          remainder_d = ge_s ? diff_s[31:0] : shifted_s[31:0];
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      count_q     <= 6'd0;
      divisor_q   <= 32'd0;
      quotient_q  <= 32'd0;
      remainder_q <= 32'd0;
      neg_quot_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
      rem_sel_q   <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_value_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      divisor_q   <= divisor_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      neg_quot_q  <= neg_quot_d;
      neg_rem_q   <= neg_rem_d;
      rem_sel_q   <= rem_sel_d;
      wb_valid_q  <= wb_valid_d;
      wb_value_q  <= wb_value_d;
    end
  end

  assign busy_o            = (state_q == ST_BUSY);
  assign writeback_valid_o = wb_valid_q;
  assign writeback_value_o = wb_value_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Directed bench for iterative_divider: vector table of divide results plus
// hand-written flush, back-to-back, ignore and mid-divide reset sequences.
module tb_iterative_divider;

  logic        clk_i;
  logic        rst_i;
  logic        opcode_valid_i;
  logic [31:0] opcode_opcode_i;
  logic [31:0] opcode_ra_operand_i;
  logic [31:0] opcode_rb_operand_i;
  logic        flush_i;
  logic        busy_o;
  logic        writeback_valid_o;
  logic [31:0] writeback_value_o;

  localparam logic [2:0] F_DIV  = 3'b100;
  localparam logic [2:0] F_DIVU = 3'b101;
  localparam logic [2:0] F_REM  = 3'b110;
  localparam logic [2:0] F_REMU = 3'b111;
  localparam logic [2:0] F_MUL  = 3'b000;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  iterative_divider dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .opcode_valid_i      (opcode_valid_i),
    .opcode_opcode_i     (opcode_opcode_i),
    .opcode_ra_operand_i (opcode_ra_operand_i),
    .opcode_rb_operand_i (opcode_rb_operand_i),
    .flush_i             (flush_i),
    .busy_o              (busy_o),
    .writeback_valid_o   (writeback_valid_o),
    .writeback_value_o   (writeback_value_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] enc(input logic [2:0] f3);
    return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present a request for one edge (called #1 after an edge), then scramble inputs.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    opcode_valid_i      = 1'b1;
    opcode_opcode_i     = enc(f3);
    opcode_ra_operand_i = a;
    opcode_rb_operand_i = b;
    @(posedge clk_i);
    #1;
    opcode_valid_i      = 1'b0;
    opcode_ra_operand_i = 32'h1234_5678;
    opcode_rb_operand_i = 32'h0000_0003;
  endtask

  // Count edges until writeback pulse, bounded at 40; -1 when no pulse seen.
  task automatic wait_pulse(output int edges);
    edges = 0;
    do begin
      @(posedge clk_i);
      #1;
      edges++;
    end while (!writeback_valid_o && edges < 40);
    if (!writeback_valid_o) edges = -1;
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk_i);
      #1;
      if (writeback_valid_o) pulses++;
    end
  endtask

  vec_t vecs[16];
  int   edges;
  int   pulses;

  initial begin
    vecs[0]  = '{F_DIVU, 32'd100,        32'd7,          32'h0000000E};
    vecs[1]  = '{F_REMU, 32'd100,        32'd7,          32'h00000002};
    vecs[2]  = '{F_DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD};
    vecs[3]  = '{F_REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF};
    vecs[4]  = '{F_DIV,  32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD};
    vecs[5]  = '{F_REM,  32'd7,          32'hFFFFFFFE,   32'h00000001};
    vecs[6]  = '{F_DIV,  32'd5,          32'd0,          32'hFFFFFFFF};
    vecs[7]  = '{F_REMU, 32'hDEADBEEF,   32'd0,          32'hDEADBEEF};
    vecs[8]  = '{F_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000};
    vecs[9]  = '{F_REM,  32'h80000000,   32'hFFFFFFFF,   32'h00000000};
    vecs[10] = '{F_DIV,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2};
    vecs[11] = '{F_REM,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE};
    vecs[12] = '{F_DIVU, 32'h80000000,   32'd2,          32'h40000000};
    vecs[13] = '{F_DIVU, 32'd1,          32'hFFFFFFFF,   32'h00000000};
    vecs[14] = '{F_REMU, 32'hFFFFFFFF,   32'h00000010,   32'h0000000F};
    vecs[15] = '{F_REM,  32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB};

    rst_i               = 1'b1;
    opcode_valid_i      = 1'b0;
    opcode_opcode_i     = 32'd0;
    opcode_ra_operand_i = 32'd0;
    opcode_rb_operand_i = 32'd0;
    flush_i             = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_busy",  {31'd0, busy_o},            32'd0);
    check("reset_valid", {31'd0, writeback_valid_o}, 32'd0);
    check("reset_value", writeback_value_o,          32'd0);
    rst_i = 1'b0;

    // Vector table; first request lands on the first edge after reset release.
    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].f3, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_busy", i), {31'd0, busy_o}, 32'd1);
      wait_pulse(edges);
      check($sformatf("v%0d_latency", i), edges, 32'd33);
      check($sformatf("v%0d_value", i), writeback_value_o, vecs[i].exp);
      check($sformatf("v%0d_busy_at_pulse", i), {31'd0, busy_o}, 32'd0);
      @(posedge clk_i);
      #1;
      check($sformatf("v%0d_pulse_width", i), {31'd0, writeback_valid_o}, 32'd0);
      check($sformatf("v%0d_value_held", i), writeback_value_o, vecs[i].exp);
    end

    // Flush mid-divide: no pulse, value retained, then a fresh divide works.
    issue(F_DIVU, 32'd100, 32'd7);
    wait_pulse(edges);
    check("pre_flush_value", writeback_value_o, 32'h0000000E);
    @(posedge clk_i);
    #1;
    issue(F_DIVU, 32'd500, 32'd7);
    repeat (10) @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    check("flush_busy", {31'd0, busy_o}, 32'd0);
    count_pulses(40, pulses);
    check("flush_no_pulse", pulses, 32'd0);
    check("flush_value_kept", writeback_value_o, 32'h0000000E);
    issue(F_DIVU, 32'd9, 32'd3);
    wait_pulse(edges);
    check("post_flush_latency", edges, 32'd33);
    check("post_flush_value", writeback_value_o, 32'h00000003);
    @(posedge clk_i);
    #1;

    // Flush coincident with a request: not accepted.
    flush_i = 1'b1;
    issue(F_DIVU, 32'd8, 32'd2);
    flush_i = 1'b0;
    check("flush_vs_valid_busy", {31'd0, busy_o}, 32'd0);

    // MUL opcode in idle is ignored.
    issue(F_MUL, 32'd6, 32'd7);
    check("mul_busy", {31'd0, busy_o}, 32'd0);
    count_pulses(5, pulses);
    check("mul_no_pulse", pulses, 32'd0);

    // Back-to-back: second issue in the pulse cycle of the first.
    issue(F_DIVU, 32'd100, 32'd7);
    wait_pulse(edges);
    check("b2b_first_value", writeback_value_o, 32'h0000000E);
    issue(F_DIVU, 32'd50, 32'd5);
    check("b2b_second_busy", {31'd0, busy_o}, 32'd1);
    repeat (5) @(posedge clk_i);
    #1;
    issue(F_DIVU, 32'd1, 32'd1);
    wait_pulse(edges);
    check("b2b_gap", edges + 7, 32'd34);
    check("b2b_second_value", writeback_value_o, 32'd10);
    @(posedge clk_i);
    #1;

    // Reset at iteration 15 discards the divide.
    issue(F_DIVU, 32'd100, 32'd7);
    repeat (15) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    check("midrst_busy",  {31'd0, busy_o},            32'd0);
    check("midrst_valid", {31'd0, writeback_valid_o}, 32'd0);
    check("midrst_value", writeback_value_o,          32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    count_pulses(40, pulses);
    check("midrst_no_pulse", pulses, 32'd0);
    issue(F_REMU, 32'd100, 32'd7);
    wait_pulse(edges);
    check("postrst_latency", edges, 32'd33);
    check("postrst_value", writeback_value_o, 32'h00000002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
